// File: rtl/lsu.sv
// Load/store unit: turns the ALU result into a word-aligned memory access (or passes it
// through), lane-aligns/extends load data and returns one result per instruction to writeback.
// Latency: non-memory op 1 cycle, memory op 2 cycles + grant wait + response wait.
// Backpressure: accepts only in IDLE; a result is held in DONE until wb_ready_i.
// Ports: exu_* in from execute, mem_* request/response port, wb_* out to writeback.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid_i,
  output logic        lsu_ready_o,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  rd_i,
  input  logic        wen_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_wen_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [15:0] cnt_q, cnt_d;

  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, wb_err_q, wb_err_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  // Incoming-op decode and store lane formatting, evaluated on the accept cycle.
  logic        in_is_mem, in_is_store, in_misal;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;

  always_comb begin
    in_is_store = mem_op_i inside {OP_SB, OP_SH, OP_SW};
    in_is_mem   = in_is_store || (mem_op_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
    in_misal    = 1'b0;
    st_wdata    = 32'h0;
    st_mask     = 4'h0;
    case (mem_op_i)
      OP_LH, OP_LHU: in_misal = alu_result_i[0];
      OP_LW:         in_misal = |alu_result_i[1:0];
      OP_SB: begin
        st_wdata = {4{rdata2_i[7:0]}};
        st_mask  = 4'b0001 << alu_result_i[1:0];
      end
      OP_SH: begin
        in_misal = alu_result_i[0];
        st_wdata = {2{rdata2_i[15:0]}};
        st_mask  = 4'b0011 << alu_result_i[1:0];
      end
      OP_SW: begin
        in_misal = |alu_result_i[1:0];
        st_wdata = rdata2_i;
        st_mask  = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0, then extend.
  logic [31:0] ld_shift, ld_data;
  logic        op_is_store;

  always_comb begin
    ld_shift    = mem_rdata_i >> {addr_q[1:0], 3'b000};
    op_is_store = op_q inside {OP_SB, OP_SH, OP_SW};
    case (op_q)
      OP_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      OP_LBU:  ld_data = {24'h0, ld_shift[7:0]};
      OP_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      OP_LHU:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  assign lsu_ready_o = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_wen_d    = wb_wen_q;
    wb_err_d    = wb_err_q;
    case (state_q)
      IDLE: begin
        if (exu_valid_i) begin
          op_d    = mem_op_i;
          addr_d  = alu_result_i;
          wen_d   = wen_i;
          wb_rd_d = rd_i;
          if (!in_is_mem) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_i;
            wb_wen_d   = wen_i;
            wb_err_d   = 1'b0;
          end else if (in_misal) begin
            // Fault reported without touching memory; data carries the bad address.
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_i;
            wb_wen_d   = 1'b0;
            wb_err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = 16'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_addr_d  = {alu_result_i[31:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_wmask_d = st_mask;
          end
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == TO) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = addr_q;
          wb_wen_d   = 1'b0;
          wb_err_d   = 1'b1;
        end else if (state_q == REQ) begin
          if (mem_gnt_i && mem_req_q) begin
            state_d   = WAIT;
            mem_req_d = 1'b0;
          end else if (cnt_q == TO - 16'd1) begin
            // Request withdrawn one cycle ahead of the timeout result, so the
            // request is visible for exactly TIMEOUT_CYCLES cycles.
            mem_req_d = 1'b0;
          end
        end else if (mem_rvalid_i) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_data_d  = op_is_store ? 32'h0 : ld_data;
          wb_wen_d   = op_is_store ? 1'b0 : wen_q;
          wb_err_d   = 1'b0;
        end
      end
      DONE: begin
        if (wb_ready_i) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 4'h0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      cnt_q       <= 16'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'h0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= 32'h0;
      wb_rd_q     <= 5'h0;
      wb_wen_q    <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_wen_q    <= wb_wen_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_data_o   = wb_data_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_wen_o    = wb_wen_q;
  assign wb_err_o    = wb_err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed instructions, expected writeback results queued at issue time
// and compared by an independent monitor on each wb handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_lsu;

  logic        clk, rst;
  logic        exu_valid_i, lsu_ready_o;
  logic [3:0]  mem_op_i;
  logic [31:0] alu_result_i, rdata2_i;
  logic [4:0]  rd_i;
  logic        wen_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_wen_o, wb_err_o;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .exu_valid_i(exu_valid_i), .lsu_ready_o(lsu_ready_o),
    .mem_op_i(mem_op_i), .alu_result_i(alu_result_i), .rdata2_i(rdata2_i),
    .rd_i(rd_i), .wen_i(wen_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_wen_o(wb_wen_o), .wb_err_o(wb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic chk_data, input logic [4:0] rd,
                      input logic wen, input logic err);
    exp_t e;
    e.data = data; e.chk_data = chk_data; e.rd = rd; e.wen = wen; e.err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: every accepted writeback result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid_o), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk_data) chk("wb_data", wb_data_o, e.data);
        chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
        chk("wb_wen", 32'(wb_wen_o), 32'(e.wen));
        chk("wb_err", 32'(wb_err_o), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wen);
    chk("ready_at_issue", 32'(lsu_ready_o), 32'h1);
    exu_valid_i = 1'b1; mem_op_i = op; alu_result_i = alu; rdata2_i = rs2;
    rd_i = rd; wen_i = wen;
    tick();
    exu_valid_i = 1'b0;
  endtask

  // Called in the first REQ cycle: grant now, respond the cycle after.
  task automatic mem_serve(input logic [31:0] rdata);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("req_dropped_after_gnt", 32'(mem_req_o), 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  // One aligned load: check request fields, serve, check result timing.
  task automatic do_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_data,
                         input logic [4:0] rd);
    push(exp_data, 1'b1, rd, 1'b1, 1'b0);
    issue(op, addr, 32'h0, rd, 1'b1);
    chk({nm, "_req"}, 32'(mem_req_o), 32'h1);
    chk({nm, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    chk({nm, "_we_mask"}, {27'h0, mem_we_o, mem_wmask_o}, 32'h0);
    mem_serve(rdata);
    chk({nm, "_valid"}, 32'(wb_valid_o), 32'h1);
    tick();
  endtask

  task automatic do_store(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_mask, input logic [4:0] rd);
    push(32'h0, 1'b1, rd, 1'b0, 1'b0);
    issue(op, addr, rs2, rd, 1'b1);
    chk({nm, "_req_we"}, {30'h0, mem_req_o, mem_we_o}, 32'h3);
    chk({nm, "_wdata"}, mem_wdata_o, exp_wdata);
    chk({nm, "_wmask"}, 32'(mem_wmask_o), 32'(exp_mask));
    mem_serve(32'hFFFF_FFFF);
    chk({nm, "_valid"}, 32'(wb_valid_o), 32'h1);
    tick();
  endtask

  initial begin
    rst = 1'b1; exu_valid_i = 1'b0; mem_op_i = 4'h0; alu_result_i = 32'h0; rdata2_i = 32'h0;
    rd_i = 5'h0; wen_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    wb_ready_i = 1'b1;
    tick(); tick();
    chk("rst_ctrl", {22'h0, mem_req_o, mem_we_o, mem_wmask_o, wb_valid_o, wb_wen_o,
                     wb_err_o, lsu_ready_o}, 32'h0);
    chk("rst_data", mem_addr_o | mem_wdata_o | wb_data_o | 32'(wb_rd_o), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(lsu_ready_o), 32'h1);
    tick();

    // Non-memory op: result one cycle after accept, no memory request.
    push(32'h0000_1234, 1'b1, 5'd5, 1'b1, 1'b0);
    issue(4'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    chk("add_valid", 32'(wb_valid_o), 32'h1);
    chk("add_noreq", 32'(mem_req_o), 32'h0);
    tick();

    do_load("lb",  4'd1, 32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80, 5'd6);
    do_load("lbu", 4'd4, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080, 5'd7);
    do_load("lh",  4'd2, 32'h8000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 5'd8);
    do_load("lhu", 4'd5, 32'h8000_0002, 32'h8001_7FFF, 32'h0000_8001, 5'd9);
    do_load("lh0", 4'd2, 32'h8000_0000, 32'h8001_7FFF, 32'h0000_7FFF, 5'd10);
    do_load("lw",  4'd3, 32'h0000_0020, 32'h1234_5678, 32'h1234_5678, 5'd11);

    do_store("sh", 4'd7, 32'h8000_0002, 32'hDEAD_BEEF, 32'hBEEF_BEEF, 4'b1100, 5'd12);
    do_store("sb", 4'd6, 32'h8000_0001, 32'h1234_56A5, 32'hA5A5_A5A5, 4'b0010, 5'd13);
    do_store("sw", 4'd8, 32'h0000_0010, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 5'd14);

    // Misaligned accesses fault with no memory request.
    push(32'h8000_0001, 1'b1, 5'd15, 1'b0, 1'b1);
    issue(4'd3, 32'h8000_0001, 32'h0, 5'd15, 1'b1);
    chk("mis_lw_noreq", 32'(mem_req_o), 32'h0);
    chk("mis_lw_valid", 32'(wb_valid_o), 32'h1);
    tick();
    push(32'h0000_0003, 1'b1, 5'd16, 1'b0, 1'b1);
    issue(4'd7, 32'h0000_0003, 32'h1111_2222, 5'd16, 1'b1);
    chk("mis_sh_noreq", 32'(mem_req_o), 32'h0);
    tick();

    // Reserved opcode behaves like NONE.
    push(32'h0BAD_F00D, 1'b1, 5'd17, 1'b1, 1'b0);
    issue(4'd12, 32'h0BAD_F00D, 32'h0, 5'd17, 1'b1);
    chk("op12_noreq", 32'(mem_req_o), 32'h0);
    tick();

    // Writeback stall: result held, no accept; queued instruction follows the handshake.
    push(32'h0000_00A1, 1'b1, 5'd18, 1'b1, 1'b0);
    issue(4'd0, 32'h0000_00A1, 32'h0, 5'd18, 1'b1);
    wb_ready_i = 1'b0;
    push(32'h0000_00B2, 1'b1, 5'd19, 1'b0, 1'b0);
    exu_valid_i = 1'b1; mem_op_i = 4'd0; alu_result_i = 32'h0000_00B2; rd_i = 5'd19; wen_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", {30'h0, wb_valid_o, lsu_ready_o}, 32'h2);
      chk("stall_data", wb_data_o, 32'h0000_00A1);
      tick();
    end
    wb_ready_i = 1'b1;
    tick();
    chk("stall_ready_after", 32'(lsu_ready_o), 32'h1);
    tick();
    exu_valid_i = 1'b0;
    chk("stall_next_valid", 32'(wb_valid_o), 32'h1);
    tick();

    // A response arriving while still in REQ is ignored.
    push(32'h55AA_55AA, 1'b1, 5'd20, 1'b1, 1'b0);
    issue(4'd3, 32'h0000_0044, 32'h0, 5'd20, 1'b1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
    tick();
    mem_rvalid_i = 1'b0;
    chk("req_rvalid_ignored", {30'h0, mem_req_o, wb_valid_o}, 32'h2);
    mem_serve(32'h55AA_55AA);
    chk("req_rvalid_valid", 32'(wb_valid_o), 32'h1);
    tick();

    // Timeout with no grant: request held 4 cycles, error result on the 6th.
    push(32'h0, 1'b0, 5'd21, 1'b0, 1'b1);
    issue(4'd3, 32'h0000_0040, 32'h0, 5'd21, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 32'(mem_req_o), 32'h1);
      tick();
    end
    chk("to_req_dropped", {30'h0, mem_req_o, wb_valid_o}, 32'h0);
    tick();
    chk("to_valid", 32'(wb_valid_o), 32'h1);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    tick();
    mem_rvalid_i = 1'b0;
    chk("to_late_rvalid", 32'(wb_valid_o), 32'h0);
    push(32'h0000_0042, 1'b1, 5'd22, 1'b1, 1'b0);
    issue(4'd0, 32'h0000_0042, 32'h0, 5'd22, 1'b1);
    chk("to_next_valid", 32'(wb_valid_o), 32'h1);
    tick();

    // Reset in WAIT: everything clears, no result from the abandoned access.
    issue(4'd3, 32'h0000_0050, 32'h0, 5'd23, 1'b1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    wb_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {22'h0, mem_req_o, mem_we_o, mem_wmask_o, wb_valid_o, wb_wen_o,
                        wb_err_o, lsu_ready_o}, 32'h0);
    chk("midrst_data", mem_addr_o | mem_wdata_o | wb_data_o | 32'(wb_rd_o), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(lsu_ready_o), 32'h1);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_5555;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    chk("midrst_no_valid", 32'(wb_valid_o), 32'h0);
    wb_ready_i = 1'b1;
    push(32'h0000_0099, 1'b1, 5'd24, 1'b1, 1'b0);
    issue(4'd0, 32'h0000_0099, 32'h0, 5'd24, 1'b1);
    chk("midrst_next_valid", 32'(wb_valid_o), 32'h1);
    tick();

    repeat (3) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
